// File: rtl/copperv_mem_responder.sv
// Memory-side responder: captures fetch/load/store request pulses on two channels and
// serves them one at a time from an internal word array, answering after LATENCY cycles.
module copperv_mem_responder #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_req,
  input  logic [31:0] ir_addr,
  output logic        ir_valid,
  output logic [31:0] ir_data,
  input  logic        dr_req,
  input  logic        dw_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] dw_data,
  input  logic [3:0]  dw_strobe,
  output logic        d_valid,
  output logic [31:0] dr_data,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;

  // Valid/ready contract: there is no ready. A request is a one-cycle pulse; it is
  // accepted when its channel has nothing pending, otherwise it is dropped and flags err.
  // Each accepted request gets exactly one one-cycle valid pulse on its own channel.

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          state_q, state_d;
  logic            gnt_d_q, gnt_d_d;   // 1: engine serves the D channel, 0: the I channel
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            first_q, first_d;
  logic            pend_i_q, pend_i_d;
  logic            pend_d_q, pend_d_d;
  logic            err_q, err_d;
  logic [31:0]     ia_q, da_q, dwd_q;
  logic [3:0]      dstb_q;
  logic            dwe_q;
  logic [31:0]     ir_data_q, dr_data_q;

  logic [31:0]     mem [DEPTH];

  // Request acceptance and protocol errors
  logic acc_i, acc_d, bad_i, bad_d, clr_i, clr_d, grant_ok;

  assign acc_i = ir_req && !pend_i_q;
  assign bad_i = ir_req && pend_i_q;
  assign acc_d = (dr_req ^ dw_req) && !pend_d_q;
  assign bad_d = (dr_req && dw_req) || ((dr_req || dw_req) && pend_d_q);

  assign clr_i = (state_q == RESP) && !gnt_d_q;
  assign clr_d = (state_q == RESP) && gnt_d_q;

  assign pend_i_d = (pend_i_q && !clr_i) || acc_i;
  assign pend_d_d = (pend_d_q && !clr_d) || acc_d;

  assign err_d = (bad_i || bad_d) ? 1'b1 : (err_clr ? 1'b0 : err_q);

  // Shared access engine datapath
  logic [31:0]   acc_addr;
  logic [AW-1:0] acc_idx;
  logic          in_range, do_access, do_write;
  logic [31:0]   rd_word;

  assign acc_addr  = gnt_d_q ? da_q : ia_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign in_range  = (acc_addr[31:AW+2] == '0);
  assign do_access = (state_q == ACCESS) && first_q;
  assign do_write  = do_access && gnt_d_q && dwe_q && in_range;
  assign rd_word   = in_range ? mem[acc_idx] : 32'h0;

  // RESP doubles as an arbitration point so a waiting channel starts without an IDLE bubble.
  always_comb begin
    state_d  = state_q;
    gnt_d_d  = gnt_d_q;
    cnt_d    = cnt_q;
    first_d  = 1'b0;
    grant_ok = 1'b0;
    case (state_q)
      IDLE:   grant_ok = 1'b1;
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        state_d  = IDLE;
        grant_ok = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (grant_ok && (pend_d_d || pend_i_d)) begin
      state_d = ACCESS;
      gnt_d_d = pend_d_d;
      cnt_d   = CW'(LATENCY - 2);
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_d_q   <= 1'b0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      pend_i_q  <= 1'b0;
      pend_d_q  <= 1'b0;
      err_q     <= 1'b0;
      ia_q      <= '0;
      da_q      <= '0;
      dwd_q     <= '0;
      dstb_q    <= '0;
      dwe_q     <= 1'b0;
      ir_data_q <= '0;
      dr_data_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_d_q  <= gnt_d_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
      err_q    <= err_d;
      if (acc_i) ia_q <= ir_addr;
      if (acc_d) begin
        da_q   <= d_addr;
        dwd_q  <= dw_data;
        dstb_q <= dw_strobe;
        dwe_q  <= dw_req;
      end
      if (do_access && !(gnt_d_q && dwe_q)) begin
        if (gnt_d_q) dr_data_q <= rd_word;
        else         ir_data_q <= rd_word;
      end
    end
  end

  // Array is deliberately not reset; the engine state gates every write.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (dstb_q[i]) mem[acc_idx][8*i +: 8] <= dwd_q[8*i +: 8];
      end
    end
  end

  assign ir_valid = (state_q == RESP) && !gnt_d_q;
  assign d_valid  = (state_q == RESP) && gnt_d_q;
  assign ir_data  = ir_data_q;
  assign dr_data  = dr_data_q;
  assign busy     = (state_q != IDLE) || pend_i_q || pend_d_q;
  assign err      = err_q;

endmodule
